jpeg_marker_writer: RTL and testbench

JPEG_MARKER_WRITER -- requirements
Module: jpeg_marker_writer

---
 rtl/jpeg_marker_writer_if.sv | 40 ++++
 rtl/jpeg_marker_writer.sv | 194 +++++++++++++++++++
 tb/tb_jpeg_marker_writer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_marker_writer_if.sv
// Bundles the command, payload and JPEG output streams of the marker writer.
// No logic: signal grouping only, with a DUT-side and a driver-side view.
// Flow control is plain valid/ready on all three streams.
interface jpeg_marker_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        pl_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        err;

  // Writer side: consumes commands and payload, produces the byte stream.
  modport slave (
    input  cmd_valid, cmd_type, cmd_code, cmd_len,
    input  pl_valid, pl_data, pl_last,
    input  out_ready,
    output cmd_ready, pl_ready,
    output out_valid, out_data, out_last,
    output busy, err
  );

  // Driver side: issues commands and payload, sinks the byte stream.
  modport master (
    output cmd_valid, cmd_type, cmd_code, cmd_len,
    output pl_valid, pl_data, pl_last,
    output out_ready,
    input  cmd_ready, pl_ready,
    input  out_valid, out_data, out_last,
    input  busy, err
  );
endinterface

// File: rtl/jpeg_marker_writer.sv
// JPEG marker/segment writer with 0xFF byte stuffing for entropy-coded data.
// Latency: payload byte to out_data is 1 cycle; marker bytes one per cycle.
// Backpressure: single output register; cmd/pl ready only when it can load.
module jpeg_marker_writer (
  input  logic               clk,
  input  logic               rst_n,
  jpeg_marker_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, MK_FF, MK_CODE, LEN_HI, LEN_LO, PAYLOAD, ENT, STUFF
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  code_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        seg_q;
  logic        eoi_q;
  logic        stuff_last_q;
  logic        live_q;
  logic        err_q;
  logic [7:0]  out_data_q;
  logic        out_valid_q;
  logic        out_last_q;

  logic        can_load;
  logic        cmd_fire;
  logic        pl_fire;
  logic        bad_seg;
  logic        ld;
  logic        ld_last;
  logic [7:0]  ld_data;
  logic        err_set;

  // The output register may take a new byte when empty or being drained.
  assign can_load      = !out_valid_q || bus.out_ready;
  // live_q keeps cmd_ready low while reset is asserted.
  assign bus.cmd_ready = live_q && (state == IDLE) && can_load;
  assign bus.pl_ready  = ((state == PAYLOAD) || (state == ENT)) && can_load;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign pl_fire       = bus.pl_valid && bus.pl_ready;

  // Length field would overflow, or the code collides with SOI/EOI/RSTn/fill.
  assign bad_seg = (bus.cmd_len > 16'd65533) ||
                   (bus.cmd_code == 8'h00) || (bus.cmd_code == 8'hFF) ||
                   (bus.cmd_code == 8'hD8) || (bus.cmd_code == 8'hD9) ||
                   (bus.cmd_code[7:3] == 5'b11010);

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != IDLE) || out_valid_q;
  assign bus.err       = err_q;

  // Next state, byte to load into the output register, protocol errors.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_data   = 8'h00;
    ld_last   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_type)
            2'd0:    state_nxt = MK_FF;
            2'd1:    state_nxt = MK_FF;
            2'd2: begin
              if (bad_seg) err_set   = 1'b1;
              else         state_nxt = MK_FF;
            end
            default: state_nxt = ENT;
          endcase
        end
      end
      MK_FF: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = 8'hFF;
          state_nxt = MK_CODE;
        end
      end
      MK_CODE: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = code_q;
          ld_last   = eoi_q;
          state_nxt = seg_q ? LEN_HI : IDLE;
        end
      end
      LEN_HI: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = len_q[15:8];
          state_nxt = LEN_LO;
        end
      end
      LEN_LO: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = len_q[7:0];
          state_nxt = (cnt_q == 16'd0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pl_fire) begin
          ld      = 1'b1;
          ld_data = bus.pl_data;
          // The byte count alone ends the segment; pl_last is only checked.
          if (cnt_q == 16'd1) begin
            state_nxt = IDLE;
            err_set   = !bus.pl_last;
          end else begin
            err_set   = bus.pl_last;
          end
        end
      end
      ENT: begin
        if (pl_fire) begin
          ld      = 1'b1;
          ld_data = bus.pl_data;
          if (bus.pl_data == 8'hFF) state_nxt = STUFF;
          else if (bus.pl_last)     state_nxt = IDLE;
        end
      end
      STUFF: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_data   = 8'h00;
          state_nxt = stuff_last_q ? IDLE : ENT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command context captured at acceptance and the payload down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q       <= 8'h00;
      len_q        <= 16'd0;
      cnt_q        <= 16'd0;
      seg_q        <= 1'b0;
      eoi_q        <= 1'b0;
      stuff_last_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        code_q <= (bus.cmd_type == 2'd0) ? 8'hD8 :
                  (bus.cmd_type == 2'd1) ? 8'hD9 : bus.cmd_code;
        eoi_q  <= (bus.cmd_type == 2'd1);
        seg_q  <= (bus.cmd_type == 2'd2);
        len_q  <= bus.cmd_len + 16'd2;
        cnt_q  <= (bus.cmd_type == 2'd2) ? bus.cmd_len : 16'd0;
      end
      if (pl_fire && (state == PAYLOAD)) cnt_q <= cnt_q - 16'd1;
      if (pl_fire && (state == ENT) && (bus.pl_data == 8'hFF))
        stuff_last_q <= bus.pl_last;
    end
  end

  // Output register: data and last hold steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else if (ld) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ld_data;
      out_last_q  <= ld_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky error flag and the post-reset enable for cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jpeg_marker_writer.sv
// Scoreboard bench for jpeg_marker_writer: expected bytes queued at stimulus.
// Output beats are popped and compared on the falling clock edge.
// out_ready is driven per cycle: steady, 1-0-0-1 pattern, or random.
module tb_jpeg_marker_writer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;
  logic [3:0] pat = 4'b1001;

  logic [8:0] exp_q[$];
  int         beats[$];
  logic       hold_vld = 1'b0;
  logic [8:0] hold_dat = 9'h0;
  logic       watch_pl = 1'b0;
  int         plr_cnt  = 0;

  jpeg_marker_writer_if bus ();

  jpeg_marker_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sink readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = pat[cyc % 4];
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: stability under stall and in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (watch_pl && bus.pl_ready) plr_cnt++;
      if (hold_vld) begin
        chk("hold_vld", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_dat", {23'd0, bus.out_last, bus.out_data}, {23'd0, hold_dat});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {23'd0, bus.out_last, bus.out_data}, 32'h1ff);
        end else begin
          chk("beat", {23'd0, bus.out_last, bus.out_data}, {23'd0, exp_q.pop_front()});
        end
        beats.push_back(cyc);
      end
      hold_vld = bus.out_valid && !bus.out_ready;
      hold_dat = {bus.out_last, bus.out_data};
    end
  end

  // Offer one command; queue the marker bytes it should produce unless bad.
  task automatic send_cmd(input logic [1:0] t, input logic [7:0] code,
                          input logic [15:0] len, input bit is_bad);
    bit ok = 1'b0;
    int n  = 0;
    logic [15:0] lf;
    lf = len + 16'd2;
    if (!is_bad) begin
      case (t)
        2'd0: begin exp_q.push_back(9'h0FF); exp_q.push_back(9'h0D8); end
        2'd1: begin exp_q.push_back(9'h0FF); exp_q.push_back(9'h1D9); end
        2'd2: begin
          exp_q.push_back(9'h0FF);
          exp_q.push_back({1'b0, code});
          exp_q.push_back({1'b0, lf[15:8]});
          exp_q.push_back({1'b0, lf[7:0]});
        end
        default: ;
      endcase
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_code  = code;
    bus.cmd_len   = len;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  // Offer one payload byte; entropy FF bytes also expect a stuffed 00.
  task automatic send_byte(input logic [7:0] d, input logic l, input bit ent);
    bit ok = 1'b0;
    int n  = 0;
    exp_q.push_back({1'b0, d});
    if (ent && d == 8'hFF) exp_q.push_back(9'h000);
    bus.pl_valid = 1'b1;
    bus.pl_data  = d;
    bus.pl_last  = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.pl_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.pl_valid = 1'b0;
    bus.pl_last  = 1'b0;
    if (!ok) chk("pl_timeout", 32'd0, 32'd1);
    if (ok && ent && d == 8'hFF) begin
      @(negedge clk);
      chk("stuff_plrdy", {31'd0, bus.pl_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd0;
    bus.cmd_code  = 8'h00;
    bus.cmd_len   = 16'd0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = 8'h00;
    bus.pl_last   = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    chk("rst_out_last",  {31'd0, bus.out_last},  32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_pl_ready",  {31'd0, bus.pl_ready},  32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_err",       {31'd0, bus.err},       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SOI, DQT segment of 3 bytes, EOI with steady sink.
    beats.delete();
    send_cmd(2'd0, 8'h00, 16'd0, 1'b0);
    send_cmd(2'd2, 8'hDB, 16'd3, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    send_byte(8'h20, 1'b1, 1'b0);
    send_cmd(2'd1, 8'h00, 16'd0, 1'b0);
    drain();
    if (beats.size() >= 11) chk("seg_contig", beats[8] - beats[2], 32'd6);
    else                    chk("beat_count", beats.size(), 32'd11);
    chk("t1_err",  {31'd0, bus.err},  32'd0);
    chk("t1_busy", {31'd0, bus.busy}, 32'd0);

    // Entropy data with stuffing, including FF on the final byte.
    send_cmd(2'd3, 8'h00, 16'd0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b0, 1'b1);
    send_byte(8'h34, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    drain();
    chk("ent_busy", {31'd0, bus.busy}, 32'd0);
    chk("ent_err",  {31'd0, bus.err},  32'd0);

    // Stalling sink: 1,0,0,1 pattern.
    rdy_mode = 1;
    send_cmd(2'd2, 8'hC4, 16'd2, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0);
    drain();

    // Random sink with random segment and entropy payloads.
    rdy_mode = 2;
    send_cmd(2'd2, 8'hE0, 16'd5, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), (i == 4), 1'b0);
    send_cmd(2'd3, 8'h00, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      send_byte((i % 3 == 1) ? 8'hFF : 8'($urandom_range(0, 254)), (i == 7), 1'b1);
    drain();
    chk("rnd_err", {31'd0, bus.err}, 32'd0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // pl_last on the second of four bytes: flagged, all bytes forwarded.
    send_cmd(2'd2, 8'hC0, 16'd4, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    drain();
    chk("plast_err", {31'd0, bus.err}, 32'd1);

    // Reset in the middle of a segment payload.
    send_cmd(2'd2, 8'hDA, 16'd4, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_err",   {31'd0, bus.err},       32'd0);
    chk("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_cmd(2'd0, 8'h00, 16'd0, 1'b0);
    drain();
    chk("post_rst_err", {31'd0, bus.err}, 32'd0);

    // Illegal segments are swallowed; zero-length segment emits header only.
    send_cmd(2'd2, 8'hD9, 16'd5, 1'b1);
    @(negedge clk);
    chk("bad_code_err", {31'd0, bus.err},       32'd1);
    chk("bad_code_rdy", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_cmd(2'd2, 8'hDB, 16'd65534, 1'b1);
    @(negedge clk);
    chk("bad_len_rdy", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    watch_pl = 1'b1;
    send_cmd(2'd2, 8'hFE, 16'd0, 1'b0);
    drain();
    watch_pl = 1'b0;
    chk("len0_plrdy", plr_cnt, 32'd0);
    chk("end_busy", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
